// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer: samples FIQ/IRQ/UND/SWI/ERET at instruction
// boundaries and issues the registered strobe sequence for the CPSR/SPSR bank.
module exc_sequencer #(
   parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_done,
   input  logic [31:0] pc_next,
   input  logic        fiq,
   input  logic        irq,
   input  logic        und_req,
   input  logic        swi_req,
   input  logic        eret_req,
   input  logic [1:0]  cpsr_if,
   output logic        W_SPSR_s,
   output logic [2:0]  W_CPSR_s,
   output logic        Write_SPSR,
   output logic        Write_CPSR,
   output logic [2:0]  Change_M,
   output logic        lr_we,
   output logic [31:0] lr_data,
   output logic        pc_we,
   output logic [31:0] pc_vec,
   output logic        busy,
   output logic [2:0]  cause
);

   typedef enum logic [2:0] {S_IDLE, S_SAVE, S_SWITCH, S_VECTOR, S_RESTORE} state_t;

   // Cause codes double as the Change_M bank-override encoding.
   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_FIQ  = 3'd1;
   localparam logic [2:0] C_IRQ  = 3'd2;
   localparam logic [2:0] C_SVC  = 3'd3;
   localparam logic [2:0] C_UND  = 3'd4;

   function automatic logic [2:0] cpsr_src(input logic [2:0] c);
      case (c)
         C_FIQ:   return 3'd3;
         C_IRQ:   return 3'd2;
         C_SVC:   return 3'd4;
         C_UND:   return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] vec_off(input logic [2:0] c);
      case (c)
         C_UND:   return 32'h04;
         C_SVC:   return 32'h08;
         C_IRQ:   return 32'h18;
         C_FIQ:   return 32'h1C;
         default: return 32'h00;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [2:0]  cause_q, cause_d;
   logic [31:0] lr_q, lr_d;
   logic [31:0] pc_vec_q, pc_vec_d;
   logic        w_spsr_s_q, w_spsr_s_d;
   logic [2:0]  w_cpsr_s_q, w_cpsr_s_d;
   logic        write_spsr_q, write_spsr_d;
   logic        write_cpsr_q, write_cpsr_d;
   logic [2:0]  change_m_q, change_m_d;
   logic        lr_we_q, lr_we_d;
   logic        pc_we_q, pc_we_d;
   logic        busy_q, busy_d;

   logic fiq_take, irq_take;

   // An eret boundary ignores interrupts so they are judged against the restored I/F.
   assign fiq_take = fiq & ~cpsr_if[0] & ~eret_req;
   assign irq_take = irq & ~cpsr_if[1] & ~eret_req;

   always_comb begin
      // NOTE: every always_comb target gets a default first so no latch is inferred.
      state_d      = state_q;
      cause_d      = cause_q;
      lr_d         = lr_q;
      pc_vec_d     = pc_vec_q;
      w_spsr_s_d   = 1'b0;
      w_cpsr_s_d   = 3'd0;
      write_spsr_d = 1'b0;
      write_cpsr_d = 1'b0;
      change_m_d   = 3'd0;
      lr_we_d      = 1'b0;
      pc_we_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (instr_done) begin
               if (fiq_take) begin
                  cause_d = C_FIQ;
                  lr_d    = pc_next + 32'd4;
                  state_d = S_SAVE;
               end else if (irq_take) begin
                  cause_d = C_IRQ;
                  lr_d    = pc_next + 32'd4;
                  state_d = S_SAVE;
               end else if (und_req) begin
                  cause_d = C_UND;
                  lr_d    = pc_next;
                  state_d = S_SAVE;
               end else if (swi_req) begin
                  cause_d = C_SVC;
                  lr_d    = pc_next;
                  state_d = S_SAVE;
               end else if (eret_req) begin
                  state_d = S_RESTORE;
               end
            end
         end
         S_SAVE:    state_d = S_SWITCH;
         S_SWITCH:  state_d = S_VECTOR;
         S_VECTOR:  state_d = S_IDLE;
         S_RESTORE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they land in the register with it.
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_SAVE: begin
            change_m_d   = cause_d;
            w_spsr_s_d   = 1'b1;
            write_spsr_d = 1'b1;
            lr_we_d      = 1'b1;
         end
         S_SWITCH: begin
            write_cpsr_d = 1'b1;
            w_cpsr_s_d   = cpsr_src(cause_d);
         end
         S_VECTOR: begin
            pc_we_d  = 1'b1;
            pc_vec_d = VEC_BASE + vec_off(cause_d);
         end
         S_RESTORE: write_cpsr_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         state_q      <= S_IDLE;
         cause_q      <= C_NONE;
         lr_q         <= 32'd0;
         pc_vec_q     <= VEC_BASE;
         w_spsr_s_q   <= 1'b0;
         w_cpsr_s_q   <= 3'd0;
         write_spsr_q <= 1'b0;
         write_cpsr_q <= 1'b0;
         change_m_q   <= 3'd0;
         lr_we_q      <= 1'b0;
         pc_we_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cause_q      <= cause_d;
         lr_q         <= lr_d;
         pc_vec_q     <= pc_vec_d;
         w_spsr_s_q   <= w_spsr_s_d;
         w_cpsr_s_q   <= w_cpsr_s_d;
         write_spsr_q <= write_spsr_d;
         write_cpsr_q <= write_cpsr_d;
         change_m_q   <= change_m_d;
         lr_we_q      <= lr_we_d;
         pc_we_q      <= pc_we_d;
         busy_q       <= busy_d;
      end
   end

   assign W_SPSR_s   = w_spsr_s_q;
   assign W_CPSR_s   = w_cpsr_s_q;
   assign Write_SPSR = write_spsr_q;
   assign Write_CPSR = write_cpsr_q;
   assign Change_M   = change_m_q;
   assign lr_we      = lr_we_q;
   assign lr_data    = lr_q;
   assign pc_we      = pc_we_q;
   assign pc_vec     = pc_vec_q;
   assign busy       = busy_q;
   assign cause      = cause_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: stimulus pushes per-cycle expected
// records, a negedge monitor pops one whenever the sequencer is active.
module tb_exc_sequencer;

   logic        clk;
   logic        rst;
   logic        instr_done;
   logic [31:0] pc_next;
   logic        fiq, irq, und_req, swi_req, eret_req;
   logic [1:0]  cpsr_if;
   logic        W_SPSR_s;
   logic [2:0]  W_CPSR_s;
   logic        Write_SPSR, Write_CPSR;
   logic [2:0]  Change_M;
   logic        lr_we;
   logic [31:0] lr_data;
   logic        pc_we;
   logic [31:0] pc_vec;
   logic        busy;
   logic [2:0]  cause;

   exc_sequencer #(.VEC_BASE(32'h0000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_done (instr_done),
      .pc_next    (pc_next),
      .fiq        (fiq),
      .irq        (irq),
      .und_req    (und_req),
      .swi_req    (swi_req),
      .eret_req   (eret_req),
      .cpsr_if    (cpsr_if),
      .W_SPSR_s   (W_SPSR_s),
      .W_CPSR_s   (W_CPSR_s),
      .Write_SPSR (Write_SPSR),
      .Write_CPSR (Write_CPSR),
      .Change_M   (Change_M),
      .lr_we      (lr_we),
      .lr_data    (lr_data),
      .pc_we      (pc_we),
      .pc_vec     (pc_vec),
      .busy       (busy),
      .cause      (cause)
   );

   typedef struct {
      string       name;
      logic        wspsr;
      logic        wcpsr;
      logic        lr_we;
      logic        pc_we;
      logic        wspsr_s;
      logic [2:0]  wcpsr_s;
      logic [2:0]  cm;
      logic [31:0] lr;
      logic [31:0] vec;
      logic [2:0]  cause;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_entry(input string nm, input logic [2:0] c, input logic [2:0] cm,
                             input logic [2:0] wc, input logic [31:0] lr, input logic [31:0] vec);
      exp_t r;
      r = '{name: {nm, ".save"}, wspsr: 1'b1, wcpsr: 1'b0, lr_we: 1'b1, pc_we: 1'b0,
            wspsr_s: 1'b1, wcpsr_s: 3'd0, cm: cm, lr: lr, vec: 32'd0, cause: c};
      exp_q.push_back(r);
      r = '{name: {nm, ".switch"}, wspsr: 1'b0, wcpsr: 1'b1, lr_we: 1'b0, pc_we: 1'b0,
            wspsr_s: 1'b0, wcpsr_s: wc, cm: 3'd0, lr: 32'd0, vec: 32'd0, cause: c};
      exp_q.push_back(r);
      r = '{name: {nm, ".vector"}, wspsr: 1'b0, wcpsr: 1'b0, lr_we: 1'b0, pc_we: 1'b1,
            wspsr_s: 1'b0, wcpsr_s: 3'd0, cm: 3'd0, lr: 32'd0, vec: vec, cause: c};
      exp_q.push_back(r);
   endtask

   task automatic push_restore(input string nm, input logic [2:0] c);
      exp_t r;
      r = '{name: {nm, ".restore"}, wspsr: 1'b0, wcpsr: 1'b1, lr_we: 1'b0, pc_we: 1'b0,
            wspsr_s: 1'b0, wcpsr_s: 3'd0, cm: 3'd0, lr: 32'd0, vec: 32'd0, cause: c};
      exp_q.push_back(r);
   endtask

   // Called just after a rising edge; presents one retiring instruction for one cycle.
   task automatic boundary(input logic f, input logic i, input logic u, input logic s,
                           input logic e, input logic [1:0] cif, input logic [31:0] pc);
      instr_done = 1'b1;
      fiq = f; irq = i; und_req = u; swi_req = s; eret_req = e;
      cpsr_if = cif; pc_next = pc;
      @(posedge clk); #1;
      instr_done = 1'b0;
      fiq = 1'b0; irq = 1'b0; und_req = 1'b0; swi_req = 1'b0; eret_req = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      repeat (5) @(posedge clk);
      #1;
      check({nm, ".drained"}, exp_q.size(), 0);
      check({nm, ".idle_busy"}, {31'd0, busy}, 0);
   endtask

   always @(negedge clk) begin
      if (mon_en && (busy || Write_SPSR || Write_CPSR || lr_we || pc_we)) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_activity: busy=%0b wspsr=%0b wcpsr=%0b lr_we=%0b pc_we=%0b, expected idle",
                     busy, Write_SPSR, Write_CPSR, lr_we, pc_we);
         end else begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, ".busy"}, {31'd0, busy}, 1);
            check({mon_e.name, ".Write_SPSR"}, {31'd0, Write_SPSR}, {31'd0, mon_e.wspsr});
            check({mon_e.name, ".Write_CPSR"}, {31'd0, Write_CPSR}, {31'd0, mon_e.wcpsr});
            check({mon_e.name, ".lr_we"}, {31'd0, lr_we}, {31'd0, mon_e.lr_we});
            check({mon_e.name, ".pc_we"}, {31'd0, pc_we}, {31'd0, mon_e.pc_we});
            check({mon_e.name, ".cause"}, {29'd0, cause}, {29'd0, mon_e.cause});
            if (mon_e.wspsr) begin
               check({mon_e.name, ".W_SPSR_s"}, {31'd0, W_SPSR_s}, {31'd0, mon_e.wspsr_s});
               check({mon_e.name, ".Change_M"}, {29'd0, Change_M}, {29'd0, mon_e.cm});
            end
            if (mon_e.wcpsr) begin
               check({mon_e.name, ".W_CPSR_s"}, {29'd0, W_CPSR_s}, {29'd0, mon_e.wcpsr_s});
               check({mon_e.name, ".Change_M"}, {29'd0, Change_M}, {29'd0, mon_e.cm});
            end
            if (mon_e.lr_we) check({mon_e.name, ".lr_data"}, lr_data, mon_e.lr);
            if (mon_e.pc_we) check({mon_e.name, ".pc_vec"}, pc_vec, mon_e.vec);
         end
      end
   end

   task automatic check_reset_state(input string nm);
      check({nm, ".busy"}, {31'd0, busy}, 0);
      check({nm, ".Write_SPSR"}, {31'd0, Write_SPSR}, 0);
      check({nm, ".Write_CPSR"}, {31'd0, Write_CPSR}, 0);
      check({nm, ".lr_we"}, {31'd0, lr_we}, 0);
      check({nm, ".pc_we"}, {31'd0, pc_we}, 0);
      check({nm, ".Change_M"}, {29'd0, Change_M}, 0);
      check({nm, ".W_CPSR_s"}, {29'd0, W_CPSR_s}, 0);
      check({nm, ".W_SPSR_s"}, {31'd0, W_SPSR_s}, 0);
      check({nm, ".cause"}, {29'd0, cause}, 0);
      check({nm, ".lr_data"}, lr_data, 32'h0);
      check({nm, ".pc_vec"}, pc_vec, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      instr_done = 1'b0; pc_next = 32'd0;
      fiq = 1'b0; irq = 1'b0; und_req = 1'b0; swi_req = 1'b0; eret_req = 1'b0;
      cpsr_if = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // IRQ entry: lr = pc+4, vector 0x18
      push_entry("irq", 3'd2, 3'd2, 3'd2, 32'h0000_0104, 32'h18);
      boundary(0, 1, 0, 0, 0, 2'b00, 32'h0000_0100);
      wait_drain("irq");

      // FIQ beats IRQ and UND when F is clear
      push_entry("prio_fiq", 3'd1, 3'd1, 3'd3, 32'h0000_0304, 32'h1C);
      boundary(1, 1, 1, 0, 0, 2'b00, 32'h0000_0300);
      wait_drain("prio_fiq");

      // F masked: IRQ wins over UND
      push_entry("prio_irq", 3'd2, 3'd2, 3'd2, 32'h0000_0404, 32'h18);
      boundary(1, 1, 1, 0, 0, 2'b01, 32'h0000_0400);
      wait_drain("prio_irq");

      // SWI: lr = pc, svc vector 0x08
      push_entry("swi", 3'd3, 3'd3, 3'd4, 32'h0000_0200, 32'h08);
      boundary(0, 0, 0, 1, 0, 2'b00, 32'h0000_0200);
      wait_drain("swi");

      // UND: lr = pc, vector 0x04
      push_entry("und", 3'd4, 3'd4, 3'd5, 32'h0000_0500, 32'h04);
      boundary(0, 0, 1, 0, 0, 2'b00, 32'h0000_0500);
      wait_drain("und");

      // UND together with eret: UND wins, eret dropped
      push_entry("und_eret", 3'd4, 3'd4, 3'd5, 32'h0000_0600, 32'h04);
      boundary(0, 0, 1, 0, 1, 2'b00, 32'h0000_0600);
      wait_drain("und_eret");

      // Eret with pending IRQ: only RESTORE, cause stays UND
      push_restore("eret", 3'd4);
      boundary(0, 1, 0, 0, 1, 2'b00, 32'h0000_0640);
      wait_drain("eret");

      // IRQ taken at the following boundary
      push_entry("irq_after_eret", 3'd2, 3'd2, 3'd2, 32'h0000_0704, 32'h18);
      boundary(0, 1, 0, 0, 0, 2'b00, 32'h0000_0700);
      wait_drain("irq_after_eret");

      // IRQ masked by I: nothing happens, cause unchanged
      boundary(0, 1, 0, 0, 0, 2'b10, 32'h0000_0900);
      wait_drain("irq_masked");
      check("irq_masked.cause", {29'd0, cause}, 2);

      // LR wraps modulo 2^32
      push_entry("wrap", 3'd2, 3'd2, 3'd2, 32'h0000_0000, 32'h18);
      boundary(0, 1, 0, 0, 0, 2'b00, 32'hFFFF_FFFC);
      wait_drain("wrap");

      // Reset during SWITCH abandons the entry; no VECTOR pulse follows
      push_entry("rst_mid", 3'd2, 3'd2, 3'd2, 32'h0000_0804, 32'h18);
      boundary(0, 1, 0, 0, 0, 2'b00, 32'h0000_0800);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
      rst = 1'b1;
      check_reset_state("rst_mid");
      wait_drain("rst_mid");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception entry/return sequencer for the CPSR/SPSR bank. It samples the interrupt lines (FIQ, IRQ) and the decode-raised exceptions (UND, SWI) at instruction boundaries. It then issues the multi-cycle strobe sequence that banks the CPSR into the target SPSR, writes the banked LR, switches the mode, and redirects the PC to the vector. It also sequences the exception-return path (restore CPSR from the current SPSR). It sits between decode/fetch control and the status-register bank, and stalls the pipeline while active.

## Interface
- VEC_BASE, 32'h0000_0000: vector table base address.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- instr_done  in  1  current instruction retires this cycle (boundary).
- pc_next  in  32  address of the next instruction to execute, valid with instr_done.
- fiq, irq  in  1 each  level-sensitive interrupt requests.
- und_req, swi_req  in  1 each  decode exceptions, valid with instr_done.
- eret_req  in  1  retiring instruction is an exception return (SUBS PC,LR / MOVS PC,LR), valid with instr_done.
- cpsr_if  in  2  CPSR[7:6] (I, F) as currently held.
- W_SPSR_s  out  1  SPSR source select (1 = CPSR).
- W_CPSR_s  out  3  CPSR source select (0 = current SPSR, 2 irq, 3 fiq, 4 svc, 5 und).
- Write_SPSR, Write_CPSR  out  1 each  bank write strobes; the bank captures them on the falling edge.
- Change_M  out  3  mode override for bank selection (0 = CPSR mode, 1 fiq, 2 irq, 3 svc, 4 und).
- lr_we  out  1  write banked LR of the target mode.
- lr_data  out  32  LR value.
- pc_we  out  1  load PC.
- pc_vec  out  32  vector address.
- busy  out  1  stall fetch/decode.
- cause  out  3  last accepted cause (0 none, 1 fiq, 2 irq, 3 svc, 4 und).

## Operation
- States: IDLE, SAVE, SWITCH, VECTOR, RESTORE. All outputs are registered and decoded from the state and the latched cause.
- **Acceptance in IDLE when instr_done=1:**
  - Priority order: FIQ (fiq & ~cpsr_if[0]) > IRQ (irq & ~cpsr_if[1]) > UND > SWI > ERET.
  - At a boundary with eret_req=1, fiq and irq are ignored; they are re-evaluated at the next boundary against the restored I/F bits.
  - If und_req and eret_req are both set, UND wins and eret is dropped.
- **Accepting an exception:**
  - Latch cause and the target codes.
  - Latch lr_data: pc_next+4 for fiq/irq, pc_next for und/svc. The add wraps modulo 2^32.
  - Next state: SAVE.
- **SAVE:**
  - Change_M = target mode, W_SPSR_s=1, Write_SPSR=1, lr_we=1.
  - Next state: SWITCH.
- **SWITCH:**
  - Change_M=0, Write_CPSR=1.
  - W_CPSR_s = target code (fiq 3, irq 2, svc 4, und 5). This sets the mode and I, and also F for fiq.
  - Next state: VECTOR.
- **VECTOR:**
  - pc_we=1, pc_vec = VEC_BASE + offset: und 0x04, svc 0x08, irq 0x18, fiq 0x1C.
  - Next state: IDLE.
- **Accepting an eret:**
  - Next state: RESTORE.
  - RESTORE: Change_M=0, W_CPSR_s=0, Write_CPSR=1. The datapath writes the PC itself.
  - Next state: IDLE. cause is unchanged.
- **Requests while not in IDLE:**
  - New requests are not sampled.
  - Interrupts are level-held by their sources. und/swi/eret cannot occur because busy holds decode.
- **Idle outputs:** all strobes 0, Change_M=0, W_CPSR_s=0, W_SPSR_s=0.

## Timing
- Reset (rst=0 at a rising edge):
  - State goes to IDLE and all strobes drop to 0 in the following cycle, including mid-sequence. A partially completed entry is abandoned.
  - cause=0, lr_data=0, pc_vec=VEC_BASE, busy=0.
- Exception latency: accepted at edge N. SAVE occupies cycle N..N+1, SWITCH N+1..N+2, VECTOR N+2..N+3. IDLE from N+3.
- busy=1 in SAVE, SWITCH, VECTOR and RESTORE. busy is 0 in the acceptance cycle itself.
- Each strobe is high for exactly one full cycle, so each produces exactly one falling-edge capture in the bank.
- Eret latency: RESTORE for one cycle, IDLE the next.
- Back-to-back: with an unmasked IRQ still asserted after eret, it is accepted at the first instr_done after RESTORE, only if the restored I=0.

## Test plan
- **IRQ entry:** irq=1, cpsr_if=00, instr_done with pc_next=0x100 -> SAVE: Change_M=2, Write_SPSR=1, W_SPSR_s=1, lr_data=0x104; SWITCH: W_CPSR_s=2, Write_CPSR=1; VECTOR: pc_vec=0x18; busy high 3 cycles.
- **Priority:** fiq=irq=und_req=1, cpsr_if=00 -> cause=1, Change_M=1, W_CPSR_s=3, pc_vec=0x1C. Repeat with cpsr_if=01 (F masked) -> cause=2, pc_vec=0x18.
- **SWI/UND:** swi_req at pc_next=0x200 -> lr_data=0x200, Change_M=3, W_CPSR_s=4, pc_vec=0x08. und_req -> Change_M=4, W_CPSR_s=5, pc_vec=0x04.
- **Eret:** eret_req with irq=1, cpsr_if=00 -> RESTORE one cycle (W_CPSR_s=0, Write_CPSR=1, Change_M=0), IRQ not taken at that boundary; taken at the next instr_done.
- **Reset mid-entry:** assert rst=0 during SWITCH -> next cycle all strobes 0, busy=0, cause=0. No pc_we pulse is issued afterwards.
- **Wrap:** irq with pc_next=0xFFFF_FFFC -> lr_data=0x0000_0000.
